// File: rtl/aes_stream_pkg.sv
// Shared constants and types for the AES word/block stream path.
// Used by both the input-side stacker and the output-side unstacker.
package aes_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

endpackage : aes_stream_pkg

// File: rtl/block_unstacker.sv
// Serialises one AES result block into NUM_WORDS words, most-significant word first.
// A new block is accepted on the same edge that the last word of the current block is taken.
module block_unstacker #(
    parameter int WORD_W    = aes_stream_pkg::WORD_W,
    parameter int NUM_WORDS = aes_stream_pkg::WORDS_PER_BLOCK
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        enable_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WORD_W*NUM_WORDS-1:0] block_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WORD_W-1:0]           word_o,
    output logic                        last_o
);

    localparam int BLOCK_W = WORD_W * NUM_WORDS;
    localparam int CNT_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    logic [BLOCK_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               full_q, full_d;

    logic on_last;
    logic take;
    logic accept;

    assign on_last = (cnt_q == LAST_IDX);
    assign valid_o = full_q & enable_i;
    assign last_o  = valid_o & on_last;
    assign take    = valid_o & ready_i;

    // Ready is held low while reset or clear is active so upstream never sees a phantom accept.
    assign ready_o = enable_i & ~clr_i & ~rst_i & (~full_q | (on_last & ready_i));
    assign accept  = valid_i & ready_o;

    always_comb begin
        word_o = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word_o = hold_q[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            hold_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (enable_i) begin
            if (take && !on_last) begin
                cnt_d = cnt_q + 1'b1;
            end else if (take && accept) begin
                hold_d = block_i;
                cnt_d  = '0;
            end else if (take) begin
                // Scrub the drained block so stale data never lingers in the holding register.
                hold_d = '0;
                cnt_d  = '0;
                full_d = 1'b0;
            end else if (accept) begin
                hold_d = block_i;
                cnt_d  = '0;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

endmodule : block_unstacker
